// File: rtl/pcihellocore_led_sequencer.sv
// Avalon-MM slave driving the LED bank with a prescaled pattern engine:
// static, blink, rotate-left or rotate-right, restarted on any configuration write.
module pcihellocore_led_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(49_999_999)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_ROTL   = 2'b10,
    MODE_ROTR   = 2'b11
  } mode_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  state_t             state;
  logic [DATA_W-1:0]  data_reg;
  logic [2:0]         ctrl_reg;
  logic [CNT_W-1:0]   period_reg;
  logic [DATA_W-1:0]  work;
  logic               phase;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        ticks;

  logic  wr;
  logic  cfg_write;
  logic  stop_write;
  logic  enable;
  mode_t mode;

  assign wr         = chipselect & ~write_n;
  assign cfg_write  = wr && (address != ADDR_STATUS);
  assign stop_write = wr && (address == ADDR_CTRL) && !writedata[0];
  assign enable     = ctrl_reg[0];
  assign mode       = mode_t'(ctrl_reg[2:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg   <= '0;
      ctrl_reg   <= '0;
      period_reg <= RST_PERIOD;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_reg   <= writedata[DATA_W-1:0];
        ADDR_CTRL:   ctrl_reg   <= writedata[2:0];
        ADDR_PERIOD: period_reg <= writedata[CNT_W-1:0];
        default:     ;
      endcase
    end
  end

  // In RUN a configuration write outranks a coincident tick: the tick action is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      work     <= '0;
      phase    <= 1'b0;
      cnt      <= RST_PERIOD;
      ticks    <= '0;
      out_port <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= period_reg;
          if (enable) state <= LOAD;
        end
        LOAD: begin
          work  <= data_reg;
          phase <= 1'b0;
          cnt   <= period_reg;
          ticks <= '0;
          state <= RUN;
        end
        RUN: begin
          if (!enable || stop_write) begin
            state <= IDLE;
          end else if (cfg_write) begin
            state <= LOAD;
          end else if (cnt == '0) begin
            cnt   <= period_reg;
            ticks <= ticks + 16'd1;
            case (mode)
              MODE_BLINK: phase <= ~phase;
              MODE_ROTL:  work  <= {work[DATA_W-2:0], work[DATA_W-1]};
              MODE_ROTR:  work  <= {work[0], work[DATA_W-1:1]};
              default:    ;
            endcase
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (state == RUN) begin
        out_port <= (mode == MODE_BLINK && phase) ? '0 : work;
      end else begin
        out_port <= data_reg;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[DATA_W-1:0] = data_reg;
      ADDR_CTRL:   readdata[2:0]        = ctrl_reg;
      ADDR_PERIOD: readdata[CNT_W-1:0]  = period_reg;
      default:     readdata = {ticks, 14'd0, phase, state == RUN};
    endcase
  end

endmodule

// File: tb/tb_pcihellocore_led_sequencer.sv
// Bench for pcihellocore_led_sequencer: directed scenarios plus random bus traffic,
// compared against a closed-form model of tick count, rotation and blink phase.
module tb_pcihellocore_led_sequencer;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;

  int n_checks;
  int n_errors;
  int cyc;

  localparam logic [31:0] RST_PERIOD = 32'd49_999_999;

  pcihellocore_led_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: 0 idle, 1 load, 2 run; a run is described by its snapshot and elapsed run cycles.
  int                m_st;
  logic [31:0]       m_data;
  logic [2:0]        m_ctrl;
  logic [31:0]       m_period;
  logic [31:0]       m_out;
  logic [15:0]       m_ticks;
  logic              m_phase;
  logic [31:0]       s_data;
  longint unsigned   s_period;
  logic [1:0]        s_mode;
  longint unsigned   m_r;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int k);
    return (x >> k) | (x << (32 - k));
  endfunction

  function automatic logic [31:0] view();
    longint unsigned n;
    int k;
    if (m_st != 2) return m_data;
    n = m_r / (s_period + 1);
    k = int'(n % 32);
    case (s_mode)
      2'd0:    return s_data;
      2'd1:    return n[0] ? 32'h0 : s_data;
      2'd2:    return rotl(s_data, k);
      default: return rotr(s_data, k);
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_data;
      2'd1:    return {29'd0, m_ctrl};
      2'd2:    return m_period;
      default: return {m_ticks, 14'd0, m_phase, m_st == 2};
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_data = '0; m_ctrl = '0; m_period = RST_PERIOD;
    m_out = '0; m_ticks = '0; m_phase = 1'b0;
    s_data = '0; s_period = 0; s_mode = '0; m_r = 0;
  endtask

  task automatic model_step(input logic rst, input logic w, input logic [1:0] a,
                            input logic [31:0] d);
    logic [31:0] nxt_out;
    longint unsigned n;
    if (rst) begin
      model_reset();
      return;
    end
    nxt_out = view();
    case (m_st)
      0: if (m_ctrl[0]) m_st = 1;
      1: begin
        s_data = m_data; s_period = longint'(m_period); s_mode = m_ctrl[2:1];
        m_r = 0; m_ticks = '0; m_phase = 1'b0; m_st = 2;
      end
      default: begin
        if (!m_ctrl[0] || (w && a == 2'd1 && !d[0])) m_st = 0;
        else if (w && a != 2'd3) m_st = 1;
        else begin
          m_r++;
          n = m_r / (s_period + 1);
          m_ticks = 16'(n % 65536);
          m_phase = (s_mode == 2'd1) ? n[0] : 1'b0;
        end
      end
    endcase
    if (w) begin
      case (a)
        2'd0:    m_data = d;
        2'd1:    m_ctrl = d[2:0];
        2'd2:    m_period = d;
        default: ;
      endcase
    end
    m_out = nxt_out;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic check_output(input logic [1:0] a);
    check("out_port", out_port, m_out);
    check($sformatf("readdata[a%0d]", a), readdata, exp_rd(a));
  endtask

  // One clock: drive at the falling edge, compare mid-cycle, then advance the model at the rising edge.
  task automatic apply_stimulus(input logic rst, input logic w, input logic [1:0] a,
                                input logic [31:0] d);
    reset = rst; chipselect = w; write_n = !w; address = a; writedata = d;
    #1;
    check_output(a);
    @(posedge clk);
    model_step(rst, w, a, d);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    apply_stimulus(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 2'd3, 32'h0);
  endtask

  logic [31:0] chg_val[$];
  int          chg_cyc[$];
  logic [31:0] last_out;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state
    apply_stimulus(1'b0, 1'b0, 2'd2, 32'h0);
    check("rst_period", readdata, 32'd49_999_999);
    check("rst_out", out_port, 32'h0);
    apply_stimulus(1'b0, 1'b0, 2'd3, 32'h0);
    check("rst_status", readdata, 32'h0);

    // Rotate-left with PERIOD=3
    wr(2'd0, 32'h1);
    wr(2'd2, 32'd3);
    wr(2'd1, 32'b101);
    check("rotl_start", out_port, 32'h1);
    last_out = out_port;
    for (int i = 0; i < 300 && readdata[31:16] != 16'd32; i++) begin
      idle(1);
      if (out_port !== last_out) begin
        chg_val.push_back(out_port);
        chg_cyc.push_back(cyc);
        last_out = out_port;
      end
    end
    check("rotl_ticks32", {16'd0, readdata[31:16]}, 32'd32);
    idle(1);
    check("rotl_wrap", out_port, 32'h1);
    check("rotl_step1", chg_val[0], 32'h2);
    check("rotl_step2", chg_val[1], 32'h4);
    check("rotl_spacing", 32'(chg_cyc[1] - chg_cyc[0]), 32'd4);

    // Blink with PERIOD=0
    wr(2'd1, 32'h0);
    idle(1);
    wr(2'd0, 32'hF0);
    wr(2'd2, 32'd0);
    wr(2'd1, 32'b011);
    idle(3);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check("blink_out", out_port, (i % 2 == 0) ? 32'h0 : 32'hF0);
      check("blink_phase", {31'd0, readdata[1]}, 32'(i % 2));
    end

    // Rotate-right; DATA write on the tick cycle
    wr(2'd1, 32'h0);
    idle(1);
    wr(2'd0, 32'h1);
    wr(2'd2, 32'd2);
    wr(2'd1, 32'b111);
    for (int i = 0; i < 50; i++) begin
      if (m_st == 2 && m_r >= 3 && (m_r % (s_period + 1)) == s_period) break;
      idle(1);
    end
    check("rotr_running", {31'd0, readdata[0]}, 32'd1);
    wr(2'd0, 32'h8000_0000);
    idle(1);
    check("collide_out", out_port, 32'h8000_0000);
    check("collide_ticks", {16'd0, readdata[31:16]}, 32'd0);
    idle(3);
    check("collide_hold", out_port, 32'h8000_0000);
    idle(1);
    check("collide_shift", out_port, 32'h4000_0000);

    // Mid-run reset
    apply_stimulus(1'b1, 1'b0, 2'd3, 32'h0);
    check("reset_out", out_port, 32'h0);
    check("reset_status", readdata, 32'h0);
    apply_stimulus(1'b0, 1'b0, 2'd1, 32'h0);
    check("reset_ctrl", readdata, 32'h0);
    apply_stimulus(1'b0, 1'b0, 2'd2, 32'h0);
    check("reset_period", readdata, RST_PERIOD);

    // CTRL cleared during RUN; STATUS write ignored
    wr(2'd0, 32'h55);
    wr(2'd2, 32'd1);
    wr(2'd1, 32'b101);
    idle(7);
    wr(2'd1, 32'h0);
    idle(1);
    check("stop_out", out_port, 32'h55);
    check("stop_run", {31'd0, readdata[0]}, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'h0);
    check("status_wr_data", readdata, 32'h55);
    apply_stimulus(1'b0, 1'b0, 2'd1, 32'h0);
    check("status_wr_ctrl", readdata, 32'h0);

    // Random bus traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst;
      logic        r_w;
      logic [1:0]  r_a;
      logic [31:0] r_d;
      int          sel;
      r_rst = ($urandom_range(0, 299) == 0);
      r_w   = (m_st != 1) && ($urandom_range(0, 9) == 0);
      r_a   = 2'($urandom_range(0, 3));
      r_d   = $urandom;
      case (r_a)
        2'd0: begin
          sel = int'($urandom_range(0, 5));
          if (sel == 0) r_d = 32'h0;
          else if (sel == 1) r_d = 32'hFFFF_FFFF;
        end
        2'd1: r_d[0] = ($urandom_range(0, 3) != 0);
        2'd2: r_d = $urandom_range(0, 4);
        default: ;
      endcase
      apply_stimulus(r_rst, r_w, r_a, r_d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
